// File: rtl/t05_sram_responder.sv
// Single-port word SRAM responder with byte-lane writes. Each accepted request
// runs IDLE -> ACCESS -> RESP. A request that is still held after RESP parks in
// DRAIN until released, so it is served only once. Out-of-range accesses touch
// no memory. They return a fixed marker word on reads and pulse err_o during RESP.
module t05_sram_responder #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_en,
    input  logic        wr_en,
    input  logic [3:0]  select,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [30:0] LP_WORDS    = 31'(MEM_WORDS);
    localparam logic [31:0] LP_OOR_WORD = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:2] r_addr;      // byte offset bits are never stored: word access only
    logic [31:0] r_wdata;
    logic [3:0]  r_sel;
    logic        r_op_wr;
    logic        r_busy;
    logic        r_err;

    logic        w_req;
    logic        w_capture;
    logic        w_in_range;
    logic [AW-1:0] w_idx;
    logic        w_mem_we;
    logic        w_rd_load;
    logic [31:0] w_rd_data;

    assign w_req      = r_en | wr_en;
    assign w_capture  = (r_state == ST_IDLE) && w_req;
    // Compare against the full word index so high addresses never alias into range.
    assign w_in_range = ({1'b0, r_addr} < LP_WORDS);
    assign w_idx      = r_addr[AW+1:2];
    // A reset that coincides with the write edge must leave memory untouched.
    assign w_mem_we   = rst && (r_state == ST_ACCESS) && r_op_wr && w_in_range;
    assign w_rd_load  = (r_state == ST_ACCESS) && !r_op_wr;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one access per request, with held requests parked in DRAIN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_req) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_RESP;
            ST_RESP:   w_state_next = w_req ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:  if (!r_en && !wr_en) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Request capture plus the busy and error flags. busy_o covers ACCESS and RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_op_wr <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr  <= addr[31:2];
                r_wdata <= data_i;
                r_sel   <= select;
                r_op_wr <= wr_en;          // write wins when both enables are high
            end
            r_busy <= (w_state_next == ST_ACCESS) || (w_state_next == ST_RESP);
            r_err  <= (r_state == ST_ACCESS) && !w_in_range;
        end
    end

    // One byte-wide RAM per lane keeps lane-enabled writes a plain per-array write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [0:MEM_WORDS-1];
            logic [7:0] r_rd;

            // Lane write: only when this lane is selected and the word is in range.
            always_ff @(posedge clk) begin
                if (w_mem_we && r_sel[gi]) begin
                    r_mem[w_idx] <= r_wdata[8*gi +: 8];
                end
            end

            // Registered lane read; it holds its value until the next read completes.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rd <= '0;
                end else if (w_rd_load) begin
                    r_rd <= w_in_range ? r_mem[w_idx] : LP_OOR_WORD[8*gi +: 8];
                end
            end

            assign w_rd_data[8*gi +: 8] = r_rd;
        end
    endgenerate

    assign data_o = w_rd_data;
    assign busy_o = r_busy;
    assign err_o  = r_err;

endmodule

// File: tb/tb_t05_sram_responder.sv
// Directed bench for t05_sram_responder. The stimulus pushes the hand-computed
// data_o/err_o expectation for each access. A monitor pops an entry each time a
// busy_o pulse ends and checks the data, the pulse length and the error pulse.
module tb_t05_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  select = '0;
    logic [31:0] addr = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        busy_o;
    logic        err_o;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    t05_sram_responder #(.MEM_WORDS(1024)) dut (
        .clk    (clk),
        .rst    (rst),
        .r_en   (r_en),
        .wr_en  (wr_en),
        .select (select),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clk = ~clk;

    // Monitor: count busy cycles, locate err_o, and score each completed access.
    int   mon_cnt = 0;
    logic mon_err = 1'b0;
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            mon_cnt  = 0;
            mon_err  = 1'b0;
            mon_prev = 1'b0;
        end else begin
            if (busy_o) mon_cnt = mon_cnt + 1;
            if (err_o) begin
                if (busy_o && mon_cnt == 2) begin
                    mon_err = 1'b1;
                end else begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL err_o_timing: err_o high at busy cycle %0d busy_o=%0b, required only in 2nd busy cycle", mon_cnt, busy_o);
                end
            end
            if (mon_prev && !busy_o) begin
                if (sb_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_access: busy pulse with data_o=%h, no access expected", data_o);
                end else begin
                    e = sb_q.pop_front();
                    checks = checks + 1;
                    if (data_o !== e.data) begin
                        errors = errors + 1;
                        $display("FAIL %s data: got %h expected %h", e.name, data_o, e.data);
                    end else $display("ok   %s data=%h", e.name, data_o);
                    checks = checks + 1;
                    if (mon_cnt != 2) begin
                        errors = errors + 1;
                        $display("FAIL %s busy_len: got %0d expected 2", e.name, mon_cnt);
                    end
                    checks = checks + 1;
                    if (mon_err !== e.err) begin
                        errors = errors + 1;
                        $display("FAIL %s err_pulse: got %0b expected %0b", e.name, mon_err, e.err);
                    end
                end
                mon_cnt = 0;
                mon_err = 1'b0;
            end
            mon_prev = busy_o;
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic er, input string nm);
        exp_t e;
        e.data = d;
        e.err  = er;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Wait, with a bound, until the monitor has scored all queued accesses.
    task automatic drain_wait(input string nm);
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s timeout: %0d accesses not completed, required 0", nm, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Called at a negedge. Drives a request for 'hold' edges, then releases it.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int hold,
                          input logic [31:0] exp_d, input logic exp_err, input string nm);
        push_exp(exp_d, exp_err, nm);
        r_en = rd; wr_en = wr; addr = a; data_i = d; select = s;
        repeat (hold) @(negedge clk);
        r_en = 1'b0; wr_en = 1'b0;
        drain_wait(nm);
    endtask

    task automatic check_now(input logic [31:0] got, input logic [31:0] req, input string nm);
        checks = checks + 1;
        if (got !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", nm, got, req);
        end else $display("ok   %s = %h", nm, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_now({31'b0, busy_o}, 32'd0, "reset_busy");
        check_now({31'b0, err_o},  32'd0, "reset_err");
        check_now(data_o, 32'h0, "reset_data");

        // First request is driven on the same edge that reset is released.
        rst = 1'b1;
        access(0, 1, 32'h400, 32'h1234_5678, 4'hF, 3, 32'h0,         0, "wr_400");
        access(1, 0, 32'h400, 32'h0,         4'hF, 3, 32'h1234_5678, 0, "rd_400");

        // Byte lanes
        access(0, 1, 32'h10, 32'hAABB_CCDD, 4'hF,    1, 32'h1234_5678, 0, "wr_10_full");
        access(0, 1, 32'h10, 32'h1122_3344, 4'b0101, 1, 32'h1234_5678, 0, "wr_10_lanes");
        access(1, 0, 32'h10, 32'h0,         4'h0,    1, 32'hAA22_CC44, 0, "rd_10");

        // Held read for 10 edges, released for one edge, then a new one-edge read.
        push_exp(32'h1234_5678, 0, "held_rd_400");
        push_exp(32'hAA22_CC44, 0, "second_rd_10");
        r_en = 1'b1; addr = 32'h400;
        repeat (10) @(negedge clk);
        r_en = 1'b0;
        @(negedge clk);
        r_en = 1'b1; addr = 32'h10;
        @(negedge clk);
        r_en = 1'b0;
        drain_wait("held");

        // Out-of-range accesses and the word-0 alias of 0x1000
        access(0, 1, 32'h0,    32'hCAFE_F00D, 4'hF, 1, 32'hAA22_CC44, 0, "wr_0");
        access(0, 1, 32'hFFC,  32'h0BAD_CAFE, 4'hF, 1, 32'hAA22_CC44, 0, "wr_last");
        access(1, 0, 32'hFFE,  32'h0,         4'hF, 1, 32'h0BAD_CAFE, 0, "rd_last_unaligned");
        access(1, 0, 32'h1000, 32'h0,         4'hF, 1, 32'hDEAD_BEEF, 1, "rd_oor");
        access(0, 1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1, 32'hDEAD_BEEF, 1, "wr_oor");
        access(1, 0, 32'h3,    32'h0,         4'hF, 1, 32'hCAFE_F00D, 0, "rd_0_after_oor");

        // Both enables: the write wins and data_o is unchanged.
        access(1, 1, 32'h20, 32'h5555_AAAA, 4'hF, 1, 32'hCAFE_F00D, 0, "both_en_20");
        access(1, 0, 32'h20, 32'h0,         4'hF, 1, 32'h5555_AAAA, 0, "rd_20");
        access(0, 1, 32'h20, 32'h0,         4'h0, 1, 32'h5555_AAAA, 0, "wr_20_nosel");
        access(1, 0, 32'h20, 32'h0,         4'hF, 1, 32'h5555_AAAA, 0, "rd_20_again");

        // Reset while a write to 0x30 is in ACCESS
        access(0, 1, 32'h30, 32'h0, 4'hF, 1, 32'h5555_AAAA, 0, "wr_30_zero");
        wr_en = 1'b1; addr = 32'h30; data_i = 32'h7777_7777; select = 4'hF;
        @(negedge clk);
        check_now({31'b0, busy_o}, 32'd1, "abort_busy_in_access");
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check_now({31'b0, busy_o}, 32'd0, "abort_busy_after_rst");
        check_now(data_o, 32'h0, "abort_data_after_rst");
        rst = 1'b1;
        access(1, 0, 32'h400, 32'h0, 4'hF, 1, 32'h1234_5678, 0, "rd_400_post_rst");
        access(1, 0, 32'h30,  32'h0, 4'hF, 1, 32'h0000_0000, 0, "rd_30_post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/t05_sram_responder.md
T05_SRAM_RESPONDER -- requirements
Module: t05_sram_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words in the backing store (byte space 0..4*MEM_WORDS-1).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port r_en  input  1  read request from the initiator.
REQ-005 SHALL have port wr_en  input  1  write request from the initiator.
REQ-006 SHALL have port select  input  4  byte-lane enables; bit n covers data bits [8n+7:8n].
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[31:2].
REQ-008 SHALL have port data_i  input  32  write data.
REQ-009 SHALL have port data_o  output  32  read data, registered.
REQ-010 SHALL have port busy_o  output  1  high while an access is in progress.
REQ-011 SHALL have port err_o  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP, DRAIN.
REQ-013 In IDLE, the first edge with r_en or wr_en high SHALL latch addr, data_i, select and op, set busy_o=1, and move to ACCESS.
REQ-014 If r_en and wr_en are both high at capture, the write SHALL win.
REQ-015 In ACCESS, a write SHALL update only the lanes with select bit set; a read SHALL load the full word into data_o; state moves to RESP.
REQ-016 In RESP, the FSM SHALL clear busy_o, then go to DRAIN if r_en or wr_en is still high, else to IDLE.
REQ-017 DRAIN SHALL ignore all requests and return to IDLE on the first edge where both r_en and wr_en are low, so a held request is served exactly once.
REQ-018 Latency: busy_o SHALL be high for exactly 2 cycles per access, rising the edge after capture.
REQ-019 data_o SHALL be valid from the edge that ends ACCESS and SHALL be held until the next read completes.
REQ-020 Writes SHALL NOT change data_o.
REQ-021 Requests arriving in ACCESS, RESP or DRAIN SHALL NOT be queued.
REQ-022 addr[1:0] SHALL be ignored (word-aligned access only).
REQ-023 Word index >= MEM_WORDS SHALL count as out of range, with no wrap-around.
REQ-024 An out-of-range write SHALL modify no memory.
REQ-025 An out-of-range read SHALL load data_o=32'hDEAD_BEEF.
REQ-026 For any out-of-range access, err_o SHALL pulse for the single cycle in which the FSM is in RESP, and busy_o timing SHALL be unchanged.
REQ-027 select=4'b0000 on a write SHALL be a legal no-op access with full busy_o timing.
REQ-028 A read SHALL return bytes written by any write that completed ACCESS earlier; there is no read-during-write hazard, since accesses are serialized.

Reset
REQ-029 While rst=0 at an edge, the block SHALL go to IDLE with busy_o=0, err_o=0, data_o=32'h0000_0000, and all latched request fields cleared.
REQ-030 Reset in ACCESS SHALL abort the access; if reset and the write-enable edge coincide, no memory write SHALL occur.
REQ-031 Memory contents SHALL NOT be cleared by reset; unwritten words are undefined.
REQ-032 The first request SHALL be capturable on the first edge with rst=1.

Verification
REQ-033 Single write/read: wr_en 3 cycles, addr=0x400, data_i=0x1234_5678, select=4'hF; then r_en 3 cycles at 0x400 -> busy_o high exactly 2 cycles each; data_o=0x1234_5678 when busy_o falls.
REQ-034 Byte lanes: word at 0x10 = 0xAABB_CCDD; write data_i=0x1122_3344 with select=4'b0101 -> read returns 0xAA22_CC44.
REQ-035 Held request: r_en held 10 cycles -> exactly one busy_o pulse of 2 cycles; DRAIN until r_en falls; a new r_en 1 cycle later starts a second access.
REQ-036 Out of range: read at byte addr 4*MEM_WORDS (0x1000) -> data_o=0xDEAD_BEEF, err_o pulses 1 cycle; a write there leaves word 0 (aliased index) unchanged.
REQ-037 Both enables: r_en=wr_en=1 at addr 0x20, data_i=0x5555_AAAA -> memory updated, data_o keeps its previous value.
REQ-038 Reset mid-access: rst=0 during ACCESS of a write to 0x30 (old 0x0) -> busy_o=0 next edge, read of 0x30 returns 0x0.
